// File: rtl/pulse_pacer_if.sv
// pulse_pacer_if: event/flush inputs and pacing status outputs of pulse_pacer
interface pulse_pacer_if #(
    parameter int CNT_W = 4
);
    logic             evt_in;
    logic             flush;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;
    modport master (output evt_in, flush, input pulse_out, pending, busy, ovf);
    modport slave (input evt_in, flush, output pulse_out, pending, busy, ovf);
endinterface

// File: rtl/pulse_pacer.sv
// pulse_pacer: paces event bursts into single-cycle pulses spaced MIN_GAP cycles apart; define PULSE_PACER_OVF_EN for a sticky overflow flag
module pulse_pacer #(
    parameter int CNT_W   = 4,
    parameter int MIN_GAP = 8
) (
    input logic          clk,
    input logic          rst,
    pulse_pacer_if.slave bus
);
    typedef enum logic {IDLE, GAP} state_t;
    state_t           state, state_nx;
    logic [7:0]       gap_cnt, gap_nx;
    logic [CNT_W-1:0] pend;
    logic             pulse_q;
    logic             fire, inc, sat;
    assign sat  = &pend;
    assign fire = ~bus.flush & (pend != '0) & ((state == IDLE) | (gap_cnt == '0));
    assign inc  = bus.evt_in & ~bus.flush & ~(sat & ~fire);
    // gap is loaded with MIN_GAP-1 so consecutive rising edges land exactly MIN_GAP apart
    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        if (fire) begin
            state_nx = GAP;
            gap_nx   = 8'(MIN_GAP - 1);
        end else if (gap_cnt != '0) begin
            gap_nx = gap_cnt - 8'd1;
        end else begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            pend    <= '0;
            pulse_q <= 1'b0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_nx;
            pulse_q <= fire;
            pend    <= bus.flush ? '0 : pend + CNT_W'(inc) - CNT_W'(fire);
        end
    end
    assign bus.pulse_out = pulse_q;
    assign bus.pending   = pend;
    assign bus.busy      = (state == GAP) | (pend != '0);
`ifdef PULSE_PACER_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk) begin
        if (rst || bus.flush) ovf_q <= 1'b0;
        else if (bus.evt_in & sat & ~fire) ovf_q <= 1'b1;
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule
